mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle main control unit. It sits directly upstream of the ALU and drives its 3-bit aluop plus all datapath enables/muxes.
//  Sequences FETCH/DECODE/execute states per instruction from opcode/funct held in the IR, and consumes the ALU zero flag to resolve branches.
// PARAMETERS
//  OPW      6  opcode and funct field width
//  ALUOPW   3  ALU operation code width
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  opcode       in   OPW     IR[31:26], stable from DECODE until FETCH
//  funct        in   OPW     IR[5:0]
//  zero         in   1       ALU compare flag (valid when aluop=100)
//  pc_en        out  1       PC register write enable
//  i_or_d       out  1       memory address mux: 0=PC, 1=ALUOut
//  mem_read     out  1       memory read strobe
//  mem_write    out  1       memory write strobe
//  ir_write     out  1       IR load enable
//  reg_dst      out  1       write-register select: 0=rt, 1=rd
//  mem_to_reg   out  1       writeback data: 0=ALUOut, 1=MDR
//  reg_write    out  1       register-file write enable
//  alu_src_a    out  1       0=PC, 1=A
//  alu_src_b    out  2       00=B, 01=4, 10=signext, 11=signext<<2
//  pc_src       out  2       00=ALU result, 01=ALUOut, 10=jump target
//  aluop        out  ALUOPW  010 add, 110 sub, 000 and, 001 or, 111 slt, 100 compare
//  instr_done   out  1       one-cycle pulse in final state of each instruction
//  illegal_op   out  1       one-cycle pulse in DECODE on unsupported op/funct
//  state        out  4       current state (debug)
// BEHAVIOUR
//  States: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 ALUWB7 BRANCH8 JUMP9; state register only sequential element.
//  Outputs Moore-decoded from state (EXEC aluop also from funct, BRANCH pc_en also from opcode/zero); unlisted outputs 0.
//  FETCH : mem_read, ir_write, pc_en=1, src_a=0, src_b=01, aluop=010, pc_src=00 -> DECODE.
//  DECODE: src_a=0, src_b=11, aluop=010 (branch target to ALUOut) -> by opcode:
//    100011 lw / 101011 sw -> MEMADR; 000000 R -> EXEC; 000100 beq -> BRANCH; 000010 j -> JUMP; else illegal_op=1 -> FETCH.
//    R-type funct not in {100000,100010,100100,100101,101010} -> illegal_op=1 -> FETCH.
//  MEMADR: src_a=1, src_b=10, aluop=010 -> MEMRD (lw) / MEMWR (sw).
//  MEMRD : mem_read, i_or_d=1 -> MEMWB.   MEMWB: reg_write, mem_to_reg=1, reg_dst=0, instr_done -> FETCH.
//  MEMWR : mem_write, i_or_d=1, instr_done -> FETCH.
//  EXEC  : src_a=1, src_b=00, aluop: add 010, sub 110, and 000, or 001, slt 111 -> ALUWB.
//  ALUWB : reg_write, reg_dst=1, mem_to_reg=0, instr_done -> FETCH.
//  BRANCH: src_a=1, src_b=00, aluop=100, pc_src=01, pc_en=zero (beq), instr_done -> FETCH.
//  JUMP  : pc_src=10, pc_en=1, instr_done -> FETCH.
//  Latency (cycles incl. FETCH): lw 5, sw 4, R 4, beq/bne 3, j 3, illegal 2.
//  Reset (any time, incl. mid-instruction): state=FETCH immediately; while rst_n=0 all enables/strobes
//    (pc_en, mem_*, ir_write, reg_write, instr_done, illegal_op) forced 0, muxes 0, aluop=010.
//    First rising edge after release is a FETCH cycle with FETCH outputs.
//  No X ever driven on outputs; zero ignored outside BRANCH.
// CONFIGURATION
//  MC_BNE_EN defined: opcode 000101 decodes to BRANCH, pc_en=~zero there; undefined: 000101 is illegal (illegal_op, -> FETCH).
// STRUCTURE
//  Package mc_pkg: state localparams, opcode/funct constants, ALUOP_* codes, alu_src_b/pc_src encodings.
//  Sub-module mc_alu_decoder: combinational funct -> {aluop, funct_legal}; used in EXEC and DECODE legality check.
// TESTING
//  Reset then release, opcode=000000 funct=100000 -> states 0,1,6,7,0; EXEC aluop=010; ALUWB reg_write=1 reg_dst=1.
//  lw (100011) -> 0,1,2,3,4; MEMRD mem_read=1 i_or_d=1; MEMWB mem_to_reg=1; instr_done only in MEMWB.
//  beq, zero=1 in BRANCH -> pc_en=1 pc_src=01 aluop=100; repeat zero=0 -> pc_en=0; sw -> 0,1,2,5 mem_write=1.
//  R funct=101010 -> EXEC aluop=111; funct=000111 -> illegal_op pulse in DECODE, next state FETCH, no reg_write.
//  opcode 000101 zero=0: with MC_BNE_EN pc_en=1 in BRANCH; without, illegal_op=1 and returns to FETCH.
//  Assert rst_n=0 mid-MEMWR -> mem_write drops to 0 same cycle, state=0; release -> FETCH outputs next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle main control unit: state
// encoding, instruction field constants, ALU operation codes and the
// datapath mux encodings driven by mc_control_fsm.
package mc_pkg;

    localparam int OPW_DEF    = 6;
    localparam int ALUOPW_DEF = 3;

    // State numbering is visible on the debug port, so it is fixed here.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_SLT = 3'b111;
    localparam logic [2:0] ALUOP_CMP = 3'b100;

    // ALU operand B select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct decoder: maps the funct field to an ALU operation code and
// flags whether the funct is one the datapath supports. Unsupported
// functs return the add code so aluop never carries an undefined value.
module mc_alu_decoder
    import mc_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic [OPW-1:0]    funct,
    output logic [ALUOPW-1:0] aluop,
    output logic              funct_legal
);

    // Pure lookup from funct to operation and legality
    always_comb begin
        aluop       = ALUOP_ADD;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  aluop = ALUOP_ADD;
            FN_SUB:  aluop = ALUOP_SUB;
            FN_AND:  aluop = ALUOP_AND;
            FN_OR:   aluop = ALUOP_OR;
            FN_SLT:  aluop = ALUOP_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control unit. Sequences FETCH/DECODE/execute states
// per instruction and Moore-decodes every datapath enable and mux select
// from the current state. The state register is the only storage; the
// outputs are combinational so that asserting rst_n low silences all
// strobes in the same cycle.
// Optional feature: define MC_BNE_EN to decode opcode 000101 (bne) as a
// branch taken on ~zero; without it that opcode is reported as illegal.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    funct,
    input  logic              zero,
    output logic              pc_en,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        pc_src,
    output logic [ALUOPW-1:0] aluop,
    output logic              instr_done,
    output logic              illegal_op,
    output logic [3:0]        state
);

    state_t              state_q;
    logic [ALUOPW-1:0]   funct_aluop;
    logic                funct_legal;
    logic                op_legal;

    mc_alu_decoder #(.OPW(OPW), .ALUOPW(ALUOPW)) u_alu_dec (
        .funct       (funct),
        .aluop       (funct_aluop),
        .funct_legal (funct_legal)
    );

    assign state = state_q;

    // Instruction legality as seen in DECODE (opcode plus R-type funct)
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
            OP_RTYPE:                   op_legal = funct_legal;
`ifdef MC_BNE_EN
            OP_BNE:                     op_legal = 1'b1;
`endif
            default:                    op_legal = 1'b0;
        endcase
    end

    // State sequencing; illegal instructions fall straight back to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH:  state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (!op_legal) begin
                        state_q <= ST_FETCH;
                    end else begin
                        case (opcode)
                            OP_LW, OP_SW: state_q <= ST_MEMADR;
                            OP_RTYPE:     state_q <= ST_EXEC;
                            OP_J:         state_q <= ST_JUMP;
                            default:      state_q <= ST_BRANCH;
                        endcase
                    end
                end
                ST_MEMADR: state_q <= (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
                ST_MEMRD:  state_q <= ST_MEMWB;
                ST_EXEC:   state_q <= ST_ALUWB;
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    // Moore output decode, forced to the quiet reset pattern while rst_n=0
    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    pc_en     = 1'b1;
                    alu_src_b = SRCB_FOUR;
                end
                ST_DECODE: begin
                    alu_src_b  = SRCB_SEXT_SH;
                    illegal_op = ~op_legal;
                end
                ST_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SEXT;
                end
                ST_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                ST_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                ST_MEMWR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = 1'b1;
                end
                ST_EXEC: begin
                    alu_src_a = 1'b1;
                    aluop     = funct_aluop;
                end
                ST_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a  = 1'b1;
                    aluop      = ALUOP_CMP;
                    pc_src     = PCSRC_ALUOUT;
                    instr_done = 1'b1;
`ifdef MC_BNE_EN
                    pc_en      = (opcode == OP_BNE) ? ~zero : zero;
`else
                    pc_en      = zero;
`endif
                end
                ST_JUMP: begin
                    pc_src     = PCSRC_JUMP;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: each instruction is expanded by a
// reference model into its list of visited states and the outputs each
// state must show, then compared cycle by cycle against the design.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] aluop;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    mc_control_fsm #(.OPW(6), .ALUOPW(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .aluop(aluop), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Observed outputs packed as {state, enables/strobes, src_b, pc_src, aluop, done, illegal}
    logic [21:0] dut_word;
    assign dut_word = {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, aluop,
                       instr_done, illegal_op};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0] legal_fn[$]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] fn_alu[$]    = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

    function automatic int fn_index(logic [5:0] fn);
        for (int i = 0; i < legal_fn.size(); i++)
            if (legal_fn[i] == fn) return i;
        return -1;
    endfunction

    function automatic bit bne_enabled();
`ifdef MC_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Ordered list of spec state numbers an instruction visits
    function automatic void build_path(input logic [5:0] op, input logic [5:0] fn, output int path[$]);
        path = '{0, 1};
        if (op == 6'b100011)                         path = '{0, 1, 2, 3, 4};
        else if (op == 6'b101011)                    path = '{0, 1, 2, 5};
        else if (op == 6'b000000 && fn_index(fn) >= 0) path = '{0, 1, 6, 7};
        else if (op == 6'b000100)                    path = '{0, 1, 8};
        else if (op == 6'b000101 && bne_enabled())   path = '{0, 1, 8};
        else if (op == 6'b000010)                    path = '{0, 1, 9};
    endfunction

    function automatic logic [21:0] exp_word(int s, logic [5:0] op, logic [5:0] fn, logic z, bit in_rst);
        logic pe = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ao = 3'b010;
        logic dn = 0, il = 0;
        int p[$];
        if (in_rst) s = 0;
        else begin
            case (s)
                0: begin mr = 1; irw = 1; pe = 1; sb = 2'b01; end
                1: begin sb = 2'b11; build_path(op, fn, p); il = (p.size() == 2); end
                2: begin sa = 1; sb = 2'b10; end
                3: begin mr = 1; iod = 1; end
                4: begin rw = 1; m2r = 1; dn = 1; end
                5: begin mw = 1; iod = 1; dn = 1; end
                6: begin sa = 1; ao = fn_alu[fn_index(fn)]; end
                7: begin rw = 1; rd = 1; dn = 1; end
                8: begin sa = 1; ao = 3'b100; ps = 2'b01; dn = 1;
                         pe = (op == 6'b000101) ? ~z : z; end
                9: begin ps = 2'b10; pe = 1; dn = 1; end
                default: ;
            endcase
        end
        return {s[3:0], pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ps, ao, dn, il};
    endfunction

    // Runs one instruction starting in its FETCH cycle (called at posedge+1).
    // zmode<0 randomizes zero every cycle; abort_at>=0 asserts reset after that step.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input int abort_at);
        int path[$];
        build_path(op, fn, path);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < path.size(); i++) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check_eq($sformatf("op%02h fn%02h step%0d", op, fn, i), 32'(dut_word),
                     32'(exp_word(path[i], op, fn, zero, 1'b0)));
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("reset mid-instr", 32'(dut_word), 32'(exp_word(0, op, fn, zero, 1'b1)));
                @(posedge clk); #1;
                check_eq("reset held", 32'(dut_word), 32'(exp_word(0, op, fn, zero, 1'b1)));
                rst_n = 1'b1;
                #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n  = 1'b0;
        opcode = 6'b100011;
        funct  = 6'b000000;
        zero   = 1'b1;
        #12;
        check_eq("reset state", 32'(dut_word), 32'(exp_word(0, opcode, funct, zero, 1'b1)));
        @(posedge clk); #1;
        opcode = 6'b000100;
        #1;
        check_eq("reset after edge", 32'(dut_word), 32'(exp_word(0, opcode, funct, zero, 1'b1)));
        rst_n = 1'b1;

        // Directed cases
        run_instr(6'b000000, 6'b100000, -1, -1);   // add
        run_instr(6'b100011, 6'b000000, -1, -1);   // lw
        run_instr(6'b000100, 6'b000000,  1, -1);   // beq taken
        run_instr(6'b000100, 6'b000000,  0, -1);   // beq not taken
        run_instr(6'b101011, 6'b000000, -1, -1);   // sw
        run_instr(6'b000000, 6'b101010, -1, -1);   // slt
        run_instr(6'b000000, 6'b000111, -1, -1);   // illegal funct
        run_instr(6'b000101, 6'b000000,  0, -1);   // bne / illegal depending on build
        run_instr(6'b000101, 6'b000000,  1, -1);
        run_instr(6'b000010, 6'b000000, -1, -1);   // j
        run_instr(6'b101011, 6'b000000, -1,  3);   // reset during MEMWR
        run_instr(6'b100011, 6'b000000, -1,  2);   // reset during MEMADR
        run_instr(6'b000000, 6'b100010, -1, -1);   // sub after reset

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op, fn;
            int kind;
            kind = $urandom_range(0, 8);
            fn   = legal_fn[$urandom_range(0, 4)];
            case (kind)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b000101;
                5: op = 6'b000010;
                6: op = 6'($urandom);
                7: begin op = 6'b000000; fn = 6'($urandom); end
                default: op = 6'b000000;
            endcase
            run_instr(op, fn, -1, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
